// File: rtl/reg_file_monitor.sv
// reg_file_monitor: shadows the integer register file, checks every enabled
// read port against the shadow copy, enforces x0-reads-zero, and reports
// failures through a one-cycle error pulse, sticky flags and a saturating count.
module reg_file_monitor #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int WRITE_FIRST  = 0,
    parameter int CNT_W        = 16,
    localparam int AW = $clog2(NUM_REGS),
    localparam int PW = (NUM_RD_PORTS < 2) ? 1 : $clog2(NUM_RD_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [AW-1:0]                  wr_reg,
    input  logic [XLEN-1:0]                wr_data,
    input  logic [NUM_RD_PORTS*AW-1:0]     rd_reg,
    input  logic [NUM_RD_PORTS*XLEN-1:0]   rd_data,
    input  logic [NUM_RD_PORTS-1:0]        rd_chk,
    input  logic                           clear,
    output logic                           err_valid,
    output logic [PW-1:0]                  err_port,
    output logic [1:0]                     err_kind,
    output logic [XLEN-1:0]                err_expected,
    output logic                           x0_sticky,
    output logic                           mismatch_sticky,
    output logic [CNT_W-1:0]               err_count
);

    // Width of the per-cycle failure count and of the widened counter sum.
    localparam int NW    = $clog2(NUM_RD_PORTS + 1);
    localparam int SUM_W = CNT_W + NW;

    localparam logic [1:0] KIND_X0 = 2'b01;
    localparam logic [1:0] KIND_MM = 2'b10;

    // Shadow copy of the register file plus written-since-reset bits.
    logic [XLEN-1:0]     shadow_q [NUM_REGS];
    logic [XLEN-1:0]     shadow_d [NUM_REGS];
    logic [NUM_REGS-1:0] valid_q;
    logic [NUM_REGS-1:0] valid_d;

    // Per-port check results.
    logic [XLEN-1:0]         port_exp [NUM_RD_PORTS];
    logic [NUM_RD_PORTS-1:0] port_vld;
    logic [NUM_RD_PORTS-1:0] fail_x0;
    logic [NUM_RD_PORTS-1:0] fail_mm;

    // Selected (lowest failing) port and failure count for this cycle.
    logic [PW-1:0]   sel_port;
    logic [1:0]      sel_kind;
    logic [XLEN-1:0] sel_exp;
    logic [NW-1:0]   n_fail;
    logic [SUM_W-1:0] cnt_sum;

    // Registered outputs.
    logic             err_valid_q, err_valid_d;
    logic [PW-1:0]    err_port_q, err_port_d;
    logic [1:0]       err_kind_q, err_kind_d;
    logic [XLEN-1:0]  err_expected_q, err_expected_d;
    logic             x0_sticky_q, x0_sticky_d;
    logic             mismatch_sticky_q, mismatch_sticky_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // Per-port expected value and failure classification.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_port
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] data;
            logic            wr_hit;

            assign addr   = rd_reg[gi*AW +: AW];
            assign data   = rd_data[gi*XLEN +: XLEN];
            // Same-cycle write forwarding only applies in write-first mode.
            assign wr_hit = (WRITE_FIRST != 0) && wr_en && (wr_reg == addr) && (addr != '0);

            assign port_exp[gi] = wr_hit ? wr_data : shadow_q[addr];
            assign port_vld[gi] = wr_hit | valid_q[addr];
            assign fail_x0[gi]  = rd_chk[gi] && (addr == '0) && (data != '0);
            assign fail_mm[gi]  = rd_chk[gi] && (addr != '0) && port_vld[gi] &&
                                  (data != port_exp[gi]);
        end
    endgenerate

    // Next shadow state: record writes, x0 stays zero and always valid.
    always_comb begin
        shadow_d = shadow_q;
        valid_d  = valid_q;
        if (wr_en && (wr_reg != '0)) begin
            shadow_d[wr_reg] = wr_data;
            valid_d[wr_reg]  = 1'b1;
        end
        shadow_d[0] = '0;
        valid_d[0]  = 1'b1;
    end

    // Pick the lowest failing port and count failing ports this cycle.
    always_comb begin
        sel_port = '0;
        sel_kind = '0;
        sel_exp  = '0;
        n_fail   = '0;
        for (int p = NUM_RD_PORTS - 1; p >= 0; p--) begin
            if (fail_x0[p] || fail_mm[p]) begin
                sel_port = PW'(p);
                sel_kind = fail_x0[p] ? KIND_X0 : KIND_MM;
                sel_exp  = port_exp[p];
            end
        end
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            n_fail = n_fail + NW'(fail_x0[p] | fail_mm[p]);
        end
    end

    // Next output state: error pulse, sticky flags and saturating counter.
    always_comb begin
        err_valid_d       = |(fail_x0 | fail_mm);
        err_port_d        = sel_port;
        err_kind_d        = sel_kind;
        err_expected_d    = sel_exp;
        cnt_sum           = SUM_W'(err_count_q) + SUM_W'(n_fail);
        x0_sticky_d       = x0_sticky_q | (|fail_x0);
        mismatch_sticky_d = mismatch_sticky_q | (|fail_mm);
        if (cnt_sum > SUM_W'({CNT_W{1'b1}})) begin
            err_count_d = {CNT_W{1'b1}};
        end else begin
            err_count_d = cnt_sum[CNT_W-1:0];
        end
        // Clear wins over anything detected in the same cycle; the pulse still fires.
        if (clear) begin
            x0_sticky_d       = 1'b0;
            mismatch_sticky_d = 1'b0;
            err_count_d       = '0;
        end
    end

    // Shadow register file state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
            end
            valid_q <= NUM_REGS'(1);
        end else begin
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
        end
    end

    // Reporting registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q       <= 1'b0;
            err_port_q        <= '0;
            err_kind_q        <= '0;
            err_expected_q    <= '0;
            x0_sticky_q       <= 1'b0;
            mismatch_sticky_q <= 1'b0;
            err_count_q       <= '0;
        end else begin
            err_valid_q       <= err_valid_d;
            err_port_q        <= err_port_d;
            err_kind_q        <= err_kind_d;
            err_expected_q    <= err_expected_d;
            x0_sticky_q       <= x0_sticky_d;
            mismatch_sticky_q <= mismatch_sticky_d;
            err_count_q       <= err_count_d;
        end
    end

    assign err_valid       = err_valid_q;
    assign err_port        = err_port_q;
    assign err_kind        = err_kind_q;
    assign err_expected    = err_expected_q;
    assign x0_sticky       = x0_sticky_q;
    assign mismatch_sticky = mismatch_sticky_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_reg_file_monitor.sv
// Testbench for reg_file_monitor: three instances share one stimulus stream
// (read-first, write-first, and a 2-bit counter) and are checked against a
// behavioural register-file model.
module tb_reg_file_monitor;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [9:0]  rd_reg;
    logic [63:0] rd_data;
    logic [1:0]  rd_chk;
    logic        clear;

    logic        o_valid [3];
    logic [0:0]  o_port  [3];
    logic [1:0]  o_kind  [3];
    logic [31:0] o_exp   [3];
    logic        o_x0s   [3];
    logic        o_mms   [3];
    logic [15:0] o_cnt   [3];
    logic [1:0]  sat_cnt_raw;

    int total = 0;
    int bad   = 0;

    // Model: architectural view of the register file and expected reports.
    logic [31:0] m_shadow [32];
    bit          m_valid  [32];
    int          cfg_wf   [3] = '{0, 1, 0};
    int          cfg_max  [3] = '{65535, 65535, 3};
    bit          e_valid  [3];
    logic [0:0]  e_port   [3];
    logic [1:0]  e_kind   [3];
    logic [31:0] e_exp    [3];
    bit          e_x0s    [3];
    bit          e_mms    [3];
    int          e_cnt    [3];

    reg_file_monitor #(.WRITE_FIRST(0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg(rd_reg), .rd_data(rd_data), .rd_chk(rd_chk), .clear(clear),
        .err_valid(o_valid[0]), .err_port(o_port[0]), .err_kind(o_kind[0]),
        .err_expected(o_exp[0]), .x0_sticky(o_x0s[0]), .mismatch_sticky(o_mms[0]),
        .err_count(o_cnt[0]));

    reg_file_monitor #(.WRITE_FIRST(1), .CNT_W(16)) dut_wf (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg(rd_reg), .rd_data(rd_data), .rd_chk(rd_chk), .clear(clear),
        .err_valid(o_valid[1]), .err_port(o_port[1]), .err_kind(o_kind[1]),
        .err_expected(o_exp[1]), .x0_sticky(o_x0s[1]), .mismatch_sticky(o_mms[1]),
        .err_count(o_cnt[1]));

    reg_file_monitor #(.WRITE_FIRST(0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg(rd_reg), .rd_data(rd_data), .rd_chk(rd_chk), .clear(clear),
        .err_valid(o_valid[2]), .err_port(o_port[2]), .err_kind(o_kind[2]),
        .err_expected(o_exp[2]), .x0_sticky(o_x0s[2]), .mismatch_sticky(o_mms[2]),
        .err_count(sat_cnt_raw));

    assign o_cnt[2] = {14'd0, sat_cnt_raw};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_shadow[i] = '0;
            m_valid[i]  = (i == 0);
        end
        for (int c = 0; c < 3; c++) begin
            e_valid[c] = 0; e_port[c] = '0; e_kind[c] = '0; e_exp[c] = '0;
            e_x0s[c] = 0; e_mms[c] = 0; e_cnt[c] = 0;
        end
    endtask

    task automatic idle();
        wr_en = 0; wr_reg = '0; wr_data = '0;
        rd_reg = '0; rd_data = '0; rd_chk = '0; clear = 0;
    endtask

    task automatic set_rd(input int p, input logic [4:0] r, input logic [31:0] d, input bit chk);
        rd_reg[p*5 +: 5]   = r;
        rd_data[p*32 +: 32] = d;
        rd_chk[p]          = chk;
    endtask

    // Advance one clock: the model evaluates the inputs seen at this edge.
    task automatic cycle();
        for (int c = 0; c < 3; c++) begin
            int nf = 0;
            bit found = 0;
            bit sx = 0, sm = 0;
            for (int p = 0; p < 2; p++) begin
                logic [4:0]  a;
                logic [31:0] d, ev;
                bit vv;
                int k;
                a = rd_reg[p*5 +: 5];
                d = rd_data[p*32 +: 32];
                if (cfg_wf[c] == 1 && wr_en && wr_reg == a && a != 0) begin
                    ev = wr_data; vv = 1;
                end else begin
                    ev = m_shadow[a]; vv = m_valid[a];
                end
                k = 0;
                if (rd_chk[p]) begin
                    if (a == 0 && d != 0) k = 1;
                    else if (a != 0 && vv && d != ev) k = 2;
                end
                if (k != 0) begin
                    nf++;
                    if (k == 1) sx = 1; else sm = 1;
                    if (!found) begin
                        found = 1; e_port[c] = 1'(p); e_kind[c] = 2'(k); e_exp[c] = ev;
                    end
                end
            end
            e_valid[c] = found;
            if (clear) begin
                e_cnt[c] = 0; e_x0s[c] = 0; e_mms[c] = 0;
            end else begin
                e_cnt[c] = (e_cnt[c] + nf > cfg_max[c]) ? cfg_max[c] : e_cnt[c] + nf;
                e_x0s[c] = e_x0s[c] | sx;
                e_mms[c] = e_mms[c] | sm;
            end
        end
        if (wr_en && wr_reg != 0) begin
            m_shadow[wr_reg] = wr_data;
            m_valid[wr_reg]  = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (o_valid[c] !== 1'b0 || o_port[c] !== 1'b0 || o_kind[c] !== 2'b00 ||
                o_exp[c] !== 32'd0 || o_x0s[c] !== 1'b0 || o_mms[c] !== 1'b0 || o_cnt[c] !== 16'd0) begin
                bad++;
                $display("FAIL reset_outputs inst=%0d: got v=%b p=%b k=%b e=%h x0=%b mm=%b cnt=%0d want all 0",
                         c, o_valid[c], o_port[c], o_kind[c], o_exp[c], o_x0s[c], o_mms[c], o_cnt[c]);
            end
        end
        rst_n = 1;
        #2;
    endtask

    task automatic test_x0_read();
        idle();
        set_rd(0, 5'd0, 32'd0, 1); set_rd(1, 5'd0, 32'd0, 1);
        cycle();
        total++;
        if (o_valid[0] !== 1'b0 || o_cnt[0] !== 16'd0) begin
            bad++; $display("FAIL x0_zero_ok: got v=%b cnt=%0d want v=0 cnt=0", o_valid[0], o_cnt[0]);
        end
        set_rd(1, 5'd0, 32'h1, 1);
        cycle();
        total++;
        if (o_valid[0] !== 1'b1 || o_port[0] !== 1'b1 || o_kind[0] !== 2'b01 ||
            o_x0s[0] !== 1'b1 || o_cnt[0] !== 16'd1) begin
            bad++;
            $display("FAIL x0_nonzero: got v=%b p=%b k=%b x0s=%b cnt=%0d want 1 1 01 1 1",
                     o_valid[0], o_port[0], o_kind[0], o_x0s[0], o_cnt[0]);
        end
        idle();
        cycle();
        total++;
        if (o_valid[0] !== 1'b0 || o_x0s[0] !== 1'b1) begin
            bad++; $display("FAIL pulse_one_cycle: got v=%b x0s=%b want v=0 x0s=1", o_valid[0], o_x0s[0]);
        end
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 1; wr_reg = 5'd5; wr_data = 32'hDEADBEEF;
        cycle();
        idle();
        set_rd(0, 5'd5, 32'hDEADBEEF, 1);
        cycle();
        total++;
        if (o_valid[0] !== 1'b0) begin
            bad++; $display("FAIL x5_match: got v=%b want 0", o_valid[0]);
        end
        set_rd(0, 5'd5, 32'hDEADBEEE, 1);
        cycle();
        total++;
        if (o_valid[0] !== 1'b1 || o_port[0] !== 1'b0 || o_kind[0] !== 2'b10 ||
            o_exp[0] !== 32'hDEADBEEF || o_mms[0] !== 1'b1 || o_cnt[0] !== 16'd2) begin
            bad++;
            $display("FAIL x5_mismatch: got v=%b p=%b k=%b e=%h mm=%b cnt=%0d want 1 0 10 deadbeef 1 2",
                     o_valid[0], o_port[0], o_kind[0], o_exp[0], o_mms[0], o_cnt[0]);
        end
    endtask

    task automatic test_write_first();
        idle();
        wr_en = 1; wr_reg = 5'd7; wr_data = 32'h22;
        cycle();
        idle();
        wr_en = 1; wr_reg = 5'd7; wr_data = 32'h11;
        set_rd(0, 5'd7, 32'h22, 1);
        cycle();
        total++;
        if (o_valid[0] !== 1'b0) begin
            bad++; $display("FAIL read_first_old: got v=%b want 0", o_valid[0]);
        end
        total++;
        if (o_valid[1] !== 1'b1 || o_kind[1] !== 2'b10 || o_exp[1] !== 32'h11) begin
            bad++;
            $display("FAIL write_first_fwd: got v=%b k=%b e=%h want 1 10 00000011",
                     o_valid[1], o_kind[1], o_exp[1]);
        end
        idle();
        set_rd(0, 5'd7, 32'h11, 1);
        cycle();
        total++;
        if (o_valid[0] !== 1'b0 || o_valid[1] !== 1'b0) begin
            bad++; $display("FAIL x7_new_value: got v0=%b v1=%b want 0 0", o_valid[0], o_valid[1]);
        end
    endtask

    task automatic test_x0_write_unwritten();
        idle();
        wr_en = 1; wr_reg = 5'd0; wr_data = 32'hFFFFFFFF;
        cycle();
        idle();
        set_rd(0, 5'd0, 32'd0, 1);
        cycle();
        total++;
        if (o_valid[0] !== 1'b0) begin
            bad++; $display("FAIL x0_write_ignored: got v=%b want 0", o_valid[0]);
        end
        set_rd(0, 5'd9, 32'h1234, 1);
        cycle();
        total++;
        if (o_valid[0] !== 1'b0 || o_cnt[0] !== 16'd2) begin
            bad++; $display("FAIL unwritten_x9: got v=%b cnt=%0d want 0 2", o_valid[0], o_cnt[0]);
        end
    endtask

    task automatic test_dual_fail_clear();
        idle();
        set_rd(0, 5'd5, 32'h0, 1);
        set_rd(1, 5'd0, 32'h5, 1);
        cycle();
        total++;
        if (o_valid[0] !== 1'b1 || o_port[0] !== 1'b0 || o_kind[0] !== 2'b10 ||
            o_exp[0] !== 32'hDEADBEEF || o_cnt[0] !== 16'd4 || o_x0s[0] !== 1'b1 || o_mms[0] !== 1'b1) begin
            bad++;
            $display("FAIL dual_fail: got v=%b p=%b k=%b e=%h cnt=%0d x0=%b mm=%b want 1 0 10 deadbeef 4 1 1",
                     o_valid[0], o_port[0], o_kind[0], o_exp[0], o_cnt[0], o_x0s[0], o_mms[0]);
        end
        idle();
        clear = 1;
        set_rd(1, 5'd0, 32'h1, 1);
        cycle();
        total++;
        if (o_valid[0] !== 1'b1 || o_cnt[0] !== 16'd0 || o_x0s[0] !== 1'b0 || o_mms[0] !== 1'b0) begin
            bad++;
            $display("FAIL clear_cycle: got v=%b cnt=%0d x0=%b mm=%b want 1 0 0 0",
                     o_valid[0], o_cnt[0], o_x0s[0], o_mms[0]);
        end
        idle();
        set_rd(0, 5'd5, 32'h1, 1);
        cycle();
        total++;
        if (o_valid[0] !== 1'b1 || o_exp[0] !== 32'hDEADBEEF || o_cnt[0] !== 16'd1) begin
            bad++;
            $display("FAIL shadow_kept: got v=%b e=%h cnt=%0d want 1 deadbeef 1", o_valid[0], o_exp[0], o_cnt[0]);
        end
    endtask

    task automatic test_saturate();
        idle();
        clear = 1;
        cycle();
        idle();
        set_rd(1, 5'd0, 32'h3, 1);
        repeat (5) cycle();
        total++;
        if (o_cnt[2] !== 16'd3 || o_cnt[0] !== 16'd5) begin
            bad++; $display("FAIL saturate: got sat=%0d full=%0d want 3 5", o_cnt[2], o_cnt[0]);
        end
        idle();
        cycle();
        total++;
        if (o_cnt[2] !== 16'd3) begin
            bad++; $display("FAIL saturate_hold: got %0d want 3", o_cnt[2]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_reg  = 5'($urandom_range(0, 7));
            wr_data = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
            clear   = ($urandom_range(0, 19) == 0);
            for (int p = 0; p < 2; p++) begin
                logic [4:0] a;
                a = 5'($urandom_range(0, 7));
                if ($urandom_range(0, 2) != 0)
                    set_rd(p, a, m_shadow[a], $urandom_range(0, 1) == 1);
                else
                    set_rd(p, a, 32'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            end
            cycle();
            for (int c = 0; c < 3; c++) begin
                total++;
                if (o_valid[c] !== e_valid[c] || o_x0s[c] !== e_x0s[c] ||
                    o_mms[c] !== e_mms[c] || o_cnt[c] !== 16'(e_cnt[c]) ||
                    (e_valid[c] && (o_port[c] !== e_port[c] || o_kind[c] !== e_kind[c] ||
                                    o_exp[c] !== e_exp[c]))) begin
                    bad++;
                    $display("FAIL random n=%0d inst=%0d: got v=%b p=%b k=%b e=%h x0=%b mm=%b cnt=%0d want v=%b p=%b k=%b e=%h x0=%b mm=%b cnt=%0d",
                             n, c, o_valid[c], o_port[c], o_kind[c], o_exp[c], o_x0s[c], o_mms[c], o_cnt[c],
                             e_valid[c], e_port[c], e_kind[c], e_exp[c], e_x0s[c], e_mms[c], e_cnt[c]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        idle();
        set_rd(1, 5'd0, 32'h7, 1);
        cycle();
        idle();
        #3;
        rst_n = 0;
        #1;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (o_valid[c] !== 1'b0 || o_kind[c] !== 2'b00 || o_exp[c] !== 32'd0 ||
                o_x0s[c] !== 1'b0 || o_mms[c] !== 1'b0 || o_cnt[c] !== 16'd0) begin
                bad++;
                $display("FAIL async_reset inst=%0d: got v=%b k=%b e=%h x0=%b mm=%b cnt=%0d want all 0",
                         c, o_valid[c], o_kind[c], o_exp[c], o_x0s[c], o_mms[c], o_cnt[c]);
            end
        end
        model_reset();
        #1;
        rst_n = 1;
        set_rd(0, 5'd5, 32'h1, 1);
        set_rd(1, 5'd7, 32'h2, 1);
        cycle();
        total++;
        if (o_valid[0] !== 1'b0 || o_valid[1] !== 1'b0 || o_cnt[0] !== 16'd0) begin
            bad++;
            $display("FAIL after_reset_unknown: got v0=%b v1=%b cnt=%0d want 0 0 0", o_valid[0], o_valid[1], o_cnt[0]);
        end
    endtask

    initial begin
        rst_n = 0;
        idle();
        model_reset();
        test_reset();
        test_x0_read();
        test_write_read();
        test_write_first();
        test_x0_write_unwritten();
        test_dual_fail_clear();
        test_saturate();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_monitor.md
# reg_file_monitor

Parametrised, synthesizable checker that shadows the integer register file and flags bad read data on every read port. It keeps its own copy of each register plus a written-since-reset bit, compares every enabled read against that copy, and enforces the x0-reads-zero rule. It sits beside the register file in the core, tapping its write and read ports without driving them. Results are a registered error pulse, sticky flags and a saturating error counter, so it can be used in simulation and observed on FPGA.

## Interface
Parameters:
- XLEN, 32, register data width
- NUM_REGS, 32, number of architectural registers (power of two, ≥2)
- NUM_RD_PORTS, 2, number of read ports monitored
- WRITE_FIRST, 0, read/write-same-cycle rule
  - 0: a read in the write cycle returns the old value
  - 1: a read in the write cycle returns wr_data
- CNT_W, 16, error counter width
- Derived: AW = log2(NUM_REGS)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  register-file write enable
- wr_reg  in  AW  write address
- wr_data  in  XLEN  write data
- rd_reg  in  NUM_RD_PORTS*AW  read addresses, flat; port p at [p*AW +: AW]
- rd_data  in  NUM_RD_PORTS*XLEN  observed read data, flat; port p at [p*XLEN +: XLEN]
- rd_chk  in  NUM_RD_PORTS  per-port compare enable
- clear  in  1  synchronous clear of flags and counter
- err_valid  out  1  one-cycle error pulse
- err_port  out  log2(max(2,NUM_RD_PORTS))  lowest failing port index
- err_kind  out  2  failure kind: 01 = x0 nonzero, 10 = data mismatch
- err_expected  out  XLEN  expected value for err_port
- x0_sticky  out  1  an x0 violation has occurred
- mismatch_sticky  out  1  a data mismatch has occurred
- err_count  out  CNT_W  total failing port-checks, saturating

## Operation
- Shadow state: shadow[NUM_REGS] of XLEN bits, and valid[NUM_REGS].
  - On wr_en with wr_reg ≠ 0: shadow[wr_reg] ← wr_data and valid[wr_reg] ← 1.
  - Writes to x0 are ignored. shadow[0] is always 0 and valid[0] is always 1.
- Expected value for port p:
  - WRITE_FIRST=1, wr_en=1, wr_reg=rd_reg_p ≠ 0: expected = wr_data, treated as valid.
  - Otherwise: expected = shadow[rd_reg_p].
- Each cycle, port p fails when rd_chk[p]=1 and one of the following holds:
  - rd_reg_p = 0 and rd_data_p ≠ 0: kind 01.
  - rd_reg_p ≠ 0, the entry is valid, and rd_data_p ≠ expected: kind 10.
- Reads of a never-written register other than x0 are not compared and never fail.
- With several failing ports, err_port/err_kind/err_expected report the lowest-index one.
- err_count adds the number of failing ports each cycle and saturates at 2^CNT_W−1.
- Sticky flags set on any failure of their kind and hold until clear or reset.
- clear=1:
  - Next edge: x0_sticky, mismatch_sticky and err_count go to 0.
  - Failures in the clear cycle still pulse err_valid but are not counted or latched.
  - Shadow and valid are not affected.

## Timing
- Reset (rst_n low, asynchronous):
  - err_valid, err_port, err_kind, err_expected, x0_sticky, mismatch_sticky and err_count go to 0.
  - All valid bits go to 0, except valid[0] = 1. Shadow contents go to 0.
- Latency:
  - A check sampled at edge N produces err_valid/err_port/err_kind/err_expected during cycle N+1, held exactly one cycle.
  - Sticky flags and counter update at the same edge N.
- Write visibility: a write sampled at edge N updates the shadow for reads checked from edge N+1 onward.
- Simultaneous write and read to the same register: the WRITE_FIRST rule applies.
- Counter at saturation stays at maximum; it never wraps.
- Reset deasserted mid-run: comparisons restart with all registers except x0 unknown.

## Test plan
- Reset, then read x0 on both ports with rd_data=0 -> err_valid stays 0 and err_count=0. Then port 1 reads x0 with 0x00000001 -> next cycle err_valid=1, err_port=1, err_kind=01, x0_sticky=1, err_count=1.
- Write x5=0xDEADBEEF, next cycle read x5 on port 0 with 0xDEADBEEF -> no error. Read x5 with 0xDEADBEEE -> err_kind=10, err_expected=0xDEADBEEF, mismatch_sticky=1.
- WRITE_FIRST=0: write x7=0x11 while reading x7 with old value 0x22 (previously written) -> no error. WRITE_FIRST=1, same stimulus -> mismatch with err_expected=0x11.
- Write x0=0xFFFFFFFF, then read x0 with 0 -> no error. Read x9 (never written) with 0x1234 -> no error.
- Both ports fail in one cycle (port 0 mismatch, port 1 x0) -> err_port=0, err_kind=10, err_count +2, both sticky flags set. Then clear -> flags and count 0, x5 shadow value retained.
- CNT_W=2: drive 5 failing cycles -> err_count saturates at 3. Assert rst_n low mid-cycle -> all outputs 0 immediately.
